lc3_mem_seq: RTL
================

# lc3_mem_seq

Memory-access sequencer for the LC-3 core. It runs the per-instruction memory access plan: the instruction fetch, then zero, one or two data accesses chosen by the opcode. It drives the shared memory handshake and the IR/MDR/PC load strobes. The total number of accesses per instruction equals the team's per-opcode memory-access count, which lets the checker compare against it directly.

## Interface
No parameters (LC-3 widths are fixed).

- clk  in  1  sole clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  run enable; sampled in IDLE and DONE only
- opcode  in  4  IR[15:12], valid from the DECODE cycle onward (BR=0 … TRAP=15)
- mem_rdy  in  1  memory completes the current access in the cycle it is high
- mem_en  out  1  access request, held until completion
- mem_we  out  1  write qualifier, meaningful only with mem_en
- mem_addr_sel  out  2  address source: 0=PC, 1=EA (datapath supplies R6 for RTI), 2=MDR, 3=trap vector
- ir_ld  out  1  load IR from read data (fetch completion)
- pc_ld  out  1  PC ← PC+1 (fetch completion)
- mdr_ld  out  1  load MDR from read data (data-read completion)
- access_cnt  out  2  accesses completed for the current instruction
- instr_done  out  1  one-cycle pulse at end of instruction
- illegal_op  out  1  one-cycle pulse in DECODE when opcode=RES
- state  out  3  current state, for debug and coverage

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, ACC1=3, ACC2=4, DONE=5.
- IDLE → FETCH when en=1.
- FETCH issues a read with sel=0. On mem_rdy=1: ir_ld=1 and pc_ld=1, then go to DECODE.
- DECODE issues no access and chooses the plan:
  - BR, ADD, JSR, AND, NOT, JMP, RES, LEA → DONE (1 access total)
  - LD, LDR → ACC1 read EA with mdr_ld (2 total)
  - ST, STR → ACC1 write EA (2 total)
  - TRAP → ACC1 read trap vector with mdr_ld (2 total)
  - RTI → ACC1 read EA with mdr_ld (2 total)
  - LDI → ACC1 read EA with mdr_ld, then ACC2 read MDR with mdr_ld (3 total)
  - STI → ACC1 read EA with mdr_ld, then ACC2 write MDR (3 total)
- ACC1 and ACC2 hold mem_en and their sel/we until mem_rdy=1, then advance. ACC1 goes to ACC2 (LDI/STI) or DONE. ACC2 goes to DONE.
- DONE pulses instr_done, then goes to FETCH if en=1, else IDLE.
- access_cnt clears to 0 on entry to FETCH and increments on each completion. In DONE it equals the opcode's memory-access count. It never exceeds 3.
- mem_we is 1 only in ST/STR ACC1 and STI ACC2.
- ir_ld, pc_ld and mdr_ld are Mealy outputs: they are asserted only in the completing cycle (mem_en & mem_rdy) of a read.
- The latched plan comes from opcode as sampled in DECODE. Opcode changes after DECODE are ignored.

## Timing
- Reset (rst=1 at an edge): state=IDLE, access_cnt=0. All outputs 0 in the following cycle, including mem_en, mem_we, all strobes, instr_done, illegal_op and mem_addr_sel.
- Reset mid-access aborts the access. mem_en drops in the cycle after the reset edge. No strobe fires.
- mem_en rises in the first cycle of FETCH/ACCn. The request is registered from state, so there is no combinational path from mem_rdy to mem_en.
- Zero-wait memory (mem_rdy tied 1): 1-access instruction = 3 cycles, 2-access = 4, 3-access = 5, each measured FETCH entry to DONE inclusive.
- Each wait cycle (mem_rdy=0) adds exactly one cycle. mem_addr_sel and mem_we stay stable while waiting.
- mem_rdy outside FETCH/ACCn is ignored.
- en=0 mid-instruction has no effect until DONE; the instruction completes.
- Back-to-back instructions: DONE is followed immediately by FETCH, with no idle cycle.

## Test plan
- Reset then en=1, mem_rdy=1, opcode=ADD(1) → state sequence 1,2,5. instr_done at cycle 3. access_cnt=1 in DONE. mem_we never 1.
- opcode=LDI(10), zero wait → reads with sel 0,1,2. mdr_ld twice. access_cnt=3 in DONE. 5 cycles total.
- opcode=STI(11), mem_rdy low for 2 cycles in ACC2 → mem_en and mem_we held 3 cycles with sel=2. instr_done 2 cycles later than in the zero-wait case.
- Loop all 16 opcodes back-to-back → access_cnt in DONE equals 1,1,2,2,1,1,2,2,2,1,3,3,1,1,1,2. illegal_op pulses only for RES(13).
- rst asserted mid-ACC1 of ST(3) → next cycle mem_en=0 and state=IDLE. No instr_done. Restart fetches from sel=0.
- en dropped during DECODE of LD(2) → instruction completes, then IDLE. mem_en stays 0 until en returns.

Source files
------------

// File: rtl/lc3_mem_seq.sv
// LC-3 per-instruction memory access sequencer: fetch, decode, then up to two
// data accesses chosen by the opcode, driving the shared memory handshake.
module lc3_mem_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] opcode,
  input  logic       mem_rdy,
  output logic       mem_en,
  output logic       mem_we,
  output logic [1:0] mem_addr_sel,
  output logic       ir_ld,
  output logic       pc_ld,
  output logic       mdr_ld,
  output logic [1:0] access_cnt,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [2:0] state
);

  // state  | meaning
  // IDLE   | waiting for en
  // FETCH  | instruction read at PC, loads IR and bumps PC on completion
  // DECODE | no access; latches the access plan from opcode
  // ACC1   | first data access (EA or trap vector)
  // ACC2   | second data access through MDR (LDI/STI only)
  // DONE   | one-cycle end-of-instruction pulse
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ACC1   = 3'd3;
  localparam logic [2:0] S_ACC2   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_ST   = 4'd3;
  localparam logic [3:0] OP_LDR  = 4'd6;
  localparam logic [3:0] OP_STR  = 4'd7;
  localparam logic [3:0] OP_RTI  = 4'd8;
  localparam logic [3:0] OP_LDI  = 4'd10;
  localparam logic [3:0] OP_STI  = 4'd11;
  localparam logic [3:0] OP_RES  = 4'd13;
  localparam logic [3:0] OP_TRAP = 4'd15;

  localparam logic [1:0] SEL_PC   = 2'd0;
  localparam logic [1:0] SEL_EA   = 2'd1;
  localparam logic [1:0] SEL_MDR  = 2'd2;
  localparam logic [1:0] SEL_TVEC = 2'd3;

  logic [2:0] state_q, state_d;
  logic [1:0] cnt_q;
  logic [1:0] plan_n_q;
  logic [1:0] sel1_q;
  logic       we1_q;
  logic       we2_q;

  logic [1:0] dec_n;
  logic [1:0] dec_sel1;
  logic       dec_we1;
  logic       dec_we2;
  logic       xfer;
  logic       fetch_entry;

  // Access plan for the opcode presented during DECODE
  always_comb begin
    dec_n    = 2'd1;
    dec_sel1 = SEL_EA;
    dec_we1  = 1'b0;
    dec_we2  = 1'b0;
    case (opcode)
      OP_LD, OP_LDR, OP_RTI: dec_n = 2'd2;
      OP_ST, OP_STR: begin
        dec_n   = 2'd2;
        dec_we1 = 1'b1;
      end
      OP_TRAP: begin
        dec_n    = 2'd2;
        dec_sel1 = SEL_TVEC;
      end
      OP_LDI: dec_n = 2'd3;
      OP_STI: begin
        dec_n   = 2'd3;
        dec_we2 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = SEL_PC;
    case (state_q)
      S_FETCH: mem_en = 1'b1;
      S_ACC1: begin
        mem_en       = 1'b1;
        mem_we       = we1_q;
        mem_addr_sel = sel1_q;
      end
      S_ACC2: begin
        mem_en       = 1'b1;
        mem_we       = we2_q;
        mem_addr_sel = SEL_MDR;
      end
      default: ;
    endcase
  end

  assign xfer = mem_en & mem_rdy;

  // Strobes are qualified by ~rst so an access aborted by reset never loads
  assign ir_ld  = xfer & ~rst & (state_q == S_FETCH);
  assign pc_ld  = ir_ld;
  assign mdr_ld = xfer & ~rst & ~mem_we & ((state_q == S_ACC1) | (state_q == S_ACC2));

  assign instr_done = (state_q == S_DONE);
  assign illegal_op = (state_q == S_DECODE) & (opcode == OP_RES);
  assign access_cnt = cnt_q;
  assign state      = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (en) state_d = S_FETCH;
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: state_d = (dec_n == 2'd1) ? S_DONE : S_ACC1;
      S_ACC1:   if (mem_rdy) state_d = (plan_n_q == 2'd3) ? S_ACC2 : S_DONE;
      S_ACC2:   if (mem_rdy) state_d = S_DONE;
      S_DONE:   state_d = en ? S_FETCH : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign fetch_entry = en & ((state_q == S_IDLE) | (state_q == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      plan_n_q <= 2'd1;
      sel1_q   <= SEL_EA;
      we1_q    <= 1'b0;
      we2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fetch_entry)
        cnt_q <= 2'd0;
      else if (xfer && cnt_q != 2'd3)
        cnt_q <= cnt_q + 2'd1;
      if (state_q == S_DECODE) begin
        plan_n_q <= dec_n;
        sel1_q   <= dec_sel1;
        we1_q    <= dec_we1;
        we2_q    <= dec_we2;
      end
    end
  end

endmodule
